// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus between two requesters and the ALU arbiter
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [1:0]        req0_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [1:0]        req1_op;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] resp_result;
    logic              resp_carry;
    logic              resp_zero;
    logic              resp_negative;
    logic              resp_overflow;
    logic              resp_err;

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_carry, resp_zero, resp_negative,
               resp_overflow, resp_err
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_carry, resp_zero, resp_negative,
               resp_overflow, resp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between execute stage and PC unit
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    output logic              busy,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_id_q, gnt_id_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [4:0]        flags_q, flags_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic              win, any_req, legal, arith;

    // next-state: winner pick and operand latch in IDLE, masked capture in ISSUE, handshake in RESP
    always_comb begin
        any_req    = |bus.req_valid;
        win        = &bus.req_valid ? ~last_gnt_q : bus.req_valid[1];
        legal      = op_q != 2'b11;
        arith      = op_q[0] ^ op_q[1];
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_id_d   = gnt_id_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        result_d   = result_q;
        flags_d    = flags_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        if (state_q == IDLE && any_req) begin
            state_d  = ISSUE;
            gnt_id_d = win;
            a_d      = win ? bus.req1_a : bus.req0_a;
            b_d      = win ? bus.req1_b : bus.req0_b;
            op_d     = win ? bus.req1_op : bus.req0_op;
            cnt0_d   = (!win && cnt0_q != '1) ? cnt0_q + 1'b1 : cnt0_q;
            cnt1_d   = (win && cnt1_q != '1) ? cnt1_q + 1'b1 : cnt1_q;
        end
        if (state_q == ISSUE) begin
            state_d  = RESP;
            result_d = legal ? alu_result : '0;
            flags_d  = {arith & alu_carry, legal & alu_zero, legal & alu_negative,
                        arith & alu_overflow, ~legal};
        end
        if (state_q == RESP && bus.resp_ready[gnt_id_q]) begin
            state_d    = IDLE;
            last_gnt_d = gnt_id_q;
        end
    end

    // state registers; last_gnt resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_id_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_id_q   <= gnt_id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE && any_req) ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_valid = (state_q == RESP) ? (gnt_id_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_result = result_q;
    assign {bus.resp_carry, bus.resp_zero, bus.resp_negative, bus.resp_overflow, bus.resp_err} = flags_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign busy     = state_q != IDLE;
    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
endmodule
